// File: rtl/regfile_bist.sv
// regfile_bist
// ------------
// Built-in self-test initiator for the 32 x 32-bit register file in the lab
// datapath. A test runs in two passes:
//   1. Fill all 32 registers with a selected pattern through the write port.
//   2. Read each register back through the asynchronous read port and compare
//      it against the expected value.
// The outcome and the mismatch count are shown on an 8-bit LED bus.
//
// Parameters:
//   ZERO_REG   : 1 when register 0 is hardwired to zero. Its expected
//                readback is then 0 for every pattern.
//
// Ports:
//   i_Clk       : clock; every state change happens on the rising edge
//   i_Reset     : synchronous active-high reset
//   i_Start     : starts a test; only looked at in IDLE
//   i_Pattern   : pattern select, latched when Start is accepted
//   o_W_Addr    : register file write address
//   o_W_Data    : register file write data
//   o_Write_Reg : register file write enable
//   o_R_Addr    : register file read address
//   i_R_Data    : register file asynchronous read data for o_R_Addr
//   o_Busy      : test in progress
//   o_Done      : one-cycle pulse when a test completes
//   o_Pass      : last test had zero mismatches
//   o_Err_Cnt   : number of mismatching registers (0..32)
//   o_Err_Addr  : address of the first mismatch, 0 if none
//   o_LED       : {Busy, Pass, Err_Cnt}
module regfile_bist #(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [1:0]  i_Pattern,
    output logic [4:0]  o_W_Addr,
    output logic [31:0] o_W_Data,
    output logic        o_Write_Reg,
    output logic [4:0]  o_R_Addr,
    input  logic [31:0] i_R_Data,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Pass,
    output logic [5:0]  o_Err_Cnt,
    output logic [4:0]  o_Err_Addr,
    output logic [7:0]  o_LED
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_pattern;
    logic [4:0]  r_wAddr;
    logic [31:0] r_wData;
    logic        r_writeReg;
    logic [4:0]  r_rAddr;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [5:0]  r_errCnt;
    logic [4:0]  r_errAddr;

    logic [31:0] w_exp;
    logic        w_mismatch;
    logic [5:0]  w_errCntNext;

    // Test pattern that is written to register a for pattern select p.
    function automatic logic [31:0] patternFn(input logic [1:0] p, input logic [4:0] a);
        logic [31:0] v;
        case (p)
            2'b00:   v = {27'b0, a};
            2'b01:   v = ~{27'b0, a};
            2'b10:   v = a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: v = 32'h1 << a;
        endcase
        return v;
    endfunction

    // The readback is the only combinational path in the block.
    // The write to register 0 is still issued. A hardwired register 0 is
    // expected to drop that write, so its expected readback is 0.
    assign w_exp        = (ZERO_REG && (r_rAddr == 5'd0)) ? 32'h0 : patternFn(r_pattern, r_rAddr);
    assign w_mismatch   = (i_R_Data != w_exp);
    assign w_errCntNext = r_errCnt + {5'b0, w_mismatch};

    // Main sequencer.
    // Every output is registered here. Start is honoured only in IDLE, so a
    // Start pulse during a test cannot restart it or stretch it.
    // The error count needs no saturation logic: there are exactly 32
    // compares, and 6 bits hold 32.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= IDLE;
            r_pattern  <= 2'b00;
            r_wAddr    <= 5'd0;
            r_wData    <= 32'h0;
            r_writeReg <= 1'b0;
            r_rAddr    <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errCnt   <= 6'd0;
            r_errAddr  <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_writeReg <= 1'b0;
                    r_rAddr    <= 5'd0;
                    if (i_Start) begin
                        r_pattern  <= i_Pattern;
                        r_errCnt   <= 6'd0;
                        r_errAddr  <= 5'd0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_wAddr    <= 5'd0;
                        r_wData    <= patternFn(i_Pattern, 5'd0);
                        r_writeReg <= 1'b1;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    // On this edge the register file stores r_wData at
                    // r_wAddr, so the next address and its data are
                    // prepared together.
                    if (r_wAddr == 5'd31) begin
                        r_writeReg <= 1'b0;
                        r_rAddr    <= 5'd0;
                        r_state    <= READ;
                    end else begin
                        r_wAddr <= r_wAddr + 5'd1;
                        r_wData <= patternFn(r_pattern, r_wAddr + 5'd1);
                    end
                end
                READ: begin
                    if (w_mismatch) begin
                        r_errCnt <= w_errCntNext;
                        if (r_errCnt == 6'd0) begin
                            r_errAddr <= r_rAddr;
                        end
                    end
                    if (r_rAddr == 5'd31) begin
                        // Results are final on the same edge that raises Done.
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_errCntNext == 6'd0);
                        r_rAddr <= 5'd0;
                        r_state <= DONE;
                    end else begin
                        r_rAddr <= r_rAddr + 5'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_W_Addr    = r_wAddr;
    assign o_W_Data    = r_wData;
    assign o_Write_Reg = r_writeReg;
    assign o_R_Addr    = r_rAddr;
    assign o_Busy      = r_busy;
    assign o_Done      = r_done;
    assign o_Pass      = r_pass;
    assign o_Err_Cnt   = r_errCnt;
    assign o_Err_Addr  = r_errAddr;
    assign o_LED       = {r_busy, r_pass, r_errCnt};

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist
// ---------------
// Self-checking bench for regfile_bist.
// It includes a behavioural register file that supports several fault modes:
//   0: normal file with register 0 hardwired to zero
//   1: bit 3 of register 5 stuck at 0
//   2: register 0 writable (stores whatever is written to it)
//   3: every read returns the inverted contents
module tb_regfile_bist;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  pattern;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic        writeReg;
    logic [4:0]  rAddr;
    logic [31:0] rData;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  errCnt;
    logic [4:0]  errAddr;
    logic [7:0]  led;

    int checksTotal  = 0;
    int checksPassed = 0;
    int faultMode    = 0;

    logic [31:0] regs [32];

    regfile_bist #(.ZERO_REG(1'b1)) dut (
        .i_Clk       (clk),
        .i_Reset     (reset),
        .i_Start     (start),
        .i_Pattern   (pattern),
        .o_W_Addr    (wAddr),
        .o_W_Data    (wData),
        .o_Write_Reg (writeReg),
        .o_R_Addr    (rAddr),
        .i_R_Data    (rData),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Pass      (pass),
        .o_Err_Cnt   (errCnt),
        .o_Err_Addr  (errAddr),
        .o_LED       (led)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file write port.
    // Register 0 ignores writes unless fault mode 2 makes it writable.
    // Fault mode 1 forces bit 3 of register 5 low as it is stored.
    always @(posedge clk) begin
        if (writeReg && (wAddr != 5'd0 || faultMode == 2)) begin
            regs[wAddr] <= (faultMode == 1 && wAddr == 5'd5) ? (wData & ~32'h8) : wData;
        end
    end

    // Asynchronous read port.
    // A hardwired register 0 always reads as zero, so contents left behind
    // by an earlier writable-register-0 run cannot leak into later tests.
    assign rData = (faultMode == 3)
                   ? ~((rAddr == 5'd0) ? 32'h0 : regs[rAddr])
                   : ((rAddr == 5'd0 && faultMode != 2) ? 32'h0 : regs[rAddr]);

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse Start for one edge (E0) and wait for Done.
    // lat reports how many edges after E0 Done was first seen (bounded).
    task automatic applyStimulus(input logic [1:0] p, output int lat);
        @(negedge clk);
        start   = 1'b1;
        pattern = p;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    typedef struct {
        logic [1:0] pat;
        int         mode;
        logic [5:0] eCnt;
        logic [4:0] eAddr;
        logic       ePass;
        logic [7:0] eLed;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat;
        int doneCount;
        int firstDone;
        int writeCount;

        start   = 1'b0;
        pattern = 2'b00;
        reset   = 1'b1;

        // Hand-computed vectors.
        // Mode 1, pattern 01: reg 5 should hold FFFFFFFA (bit 3 set), but
        // the stuck bit makes it read back as FFFFFFF2.
        // Mode 1, pattern 00: reg 5 should hold 5 (bit 3 clear), so the
        // stuck bit does no harm.
        // Mode 2, pattern 01: reg 0 reads FFFFFFFF against an expected 0.
        // Mode 3: all 32 registers mismatch, giving a count of 32 (LED 8'h20).
        vecs[0] = '{2'b00, 0, 6'd0,  5'd0, 1'b1, 8'h40};
        vecs[1] = '{2'b01, 0, 6'd0,  5'd0, 1'b1, 8'h40};
        vecs[2] = '{2'b10, 0, 6'd0,  5'd0, 1'b1, 8'h40};
        vecs[3] = '{2'b11, 0, 6'd0,  5'd0, 1'b1, 8'h40};
        vecs[4] = '{2'b01, 1, 6'd1,  5'd5, 1'b0, 8'h01};
        vecs[5] = '{2'b00, 1, 6'd0,  5'd0, 1'b1, 8'h40};
        vecs[6] = '{2'b01, 2, 6'd1,  5'd0, 1'b0, 8'h01};
        vecs[7] = '{2'b00, 2, 6'd0,  5'd0, 1'b1, 8'h40};
        vecs[8] = '{2'b10, 3, 6'd32, 5'd0, 1'b0, 8'h20};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset Write_Reg", {31'b0, writeReg}, 32'h0);
        checkOutput("reset W_Addr",    {27'b0, wAddr},    32'h0);
        checkOutput("reset W_Data",    wData,             32'h0);
        checkOutput("reset R_Addr",    {27'b0, rAddr},    32'h0);
        checkOutput("reset Done",      {31'b0, done},     32'h0);
        checkOutput("reset LED",       {24'b0, led},      32'h0);
        checkOutput("reset Err_Addr",  {27'b0, errAddr},  32'h0);
        reset = 1'b0;

        // Table-driven full tests.
        for (int i = 0; i < 9; i++) begin
            faultMode = vecs[i].mode;
            applyStimulus(vecs[i].pat, lat);
            $display("[TB] vector %0d pattern %0d mode %0d", i, vecs[i].pat, vecs[i].mode);
            checkOutput("latency",  lat,                    32'd64);
            checkOutput("Err_Cnt",  {26'b0, errCnt},        {26'b0, vecs[i].eCnt});
            checkOutput("Err_Addr", {27'b0, errAddr},       {27'b0, vecs[i].eAddr});
            checkOutput("Pass",     {31'b0, pass},          {31'b0, vecs[i].ePass});
            checkOutput("LED",      {24'b0, led},           {24'b0, vecs[i].eLed});
            @(negedge clk);
            checkOutput("Done low", {31'b0, done},          32'h0);
            checkOutput("LED held", {24'b0, led},           {24'b0, vecs[i].eLed});
        end

        // Walking-one write-phase timing.
        faultMode = 0;
        @(negedge clk);
        start   = 1'b1;
        pattern = 2'b11;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("E0 Write_Reg", {31'b0, writeReg}, 32'h1);
        checkOutput("E0 W_Addr",    {27'b0, wAddr},    32'h0);
        checkOutput("E0 W_Data",    wData,             32'h0000_0001);
        checkOutput("E0 LED",       {24'b0, led},      32'h80);
        repeat (31) @(posedge clk);
        @(negedge clk);
        checkOutput("W31 W_Addr",    {27'b0, wAddr},    32'd31);
        checkOutput("W31 W_Data",    wData,             32'h8000_0000);
        checkOutput("W31 Write_Reg", {31'b0, writeReg}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("E32 Write_Reg", {31'b0, writeReg}, 32'h0);
        checkOutput("E32 R_Addr",    {27'b0, rAddr},    32'h0);
        lat = 32;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
        checkOutput("walk latency", lat,            32'd64);
        checkOutput("walk Pass",    {31'b0, pass},  32'h1);

        // Start re-pulsed at cycles 10 and 40 of a running test.
        @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        pattern = 2'b00;
        @(posedge clk);
        #1 start = 1'b0;
        doneCount = 0;
        firstDone = 0;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                doneCount++;
                if (firstDone == 0) firstDone = k;
            end
            start = (k == 10 || k == 40);
        end
        start = 1'b0;
        checkOutput("repulse done count", doneCount,    32'd1);
        checkOutput("repulse done cycle", firstDone,    32'd64);
        checkOutput("repulse Pass",       {31'b0, pass}, 32'h1);
        checkOutput("repulse LED",        {24'b0, led},  32'h40);

        // Reset at WRITE cycle 10, with Start raised on the same edge.
        @(negedge clk);
        start   = 1'b1;
        pattern = 2'b01;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort Write_Reg", {31'b0, writeReg}, 32'h0);
        checkOutput("abort Busy",      {31'b0, busy},     32'h0);
        checkOutput("abort W_Addr",    {27'b0, wAddr},    32'h0);
        checkOutput("abort LED",       {24'b0, led},      32'h0);
        reset = 1'b0;
        start = 1'b0;
        doneCount  = 0;
        writeCount = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) doneCount++;
            if (writeReg) writeCount++;
        end
        checkOutput("abort no Done",   doneCount,  32'd0);
        checkOutput("abort no writes", writeCount, 32'd0);
        applyStimulus(2'b00, lat);
        checkOutput("post-abort latency", lat,            32'd64);
        checkOutput("post-abort Pass",    {31'b0, pass},  32'h1);
        checkOutput("post-abort LED",     {24'b0, led},   32'h40);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
